// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, fixed-latency memory between instruction fetch (IF) and data memory (DM).
// DM has priority, except that IF is forced through after STARVE consecutive DM wins while IF waits.
module mem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int LAT    = 2,
  parameter int STARVE = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  input  logic          i_if_kill,
  output logic          o_if_gnt,
  output logic          o_if_valid,
  output logic [DW-1:0] o_if_rdata,
  input  logic          i_dm_req,
  input  logic          i_dm_we,
  input  logic [AW-1:0] i_dm_addr,
  input  logic [DW-1:0] i_dm_wdata,
  input  logic [1:0]    i_dm_size,
  output logic          o_dm_gnt,
  output logic          o_dm_valid,
  output logic [DW-1:0] o_dm_rdata,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic [1:0]    o_mem_size,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_busy
);

  localparam logic       ST_IDLE  = 1'b0;
  localparam logic       ST_WAIT  = 1'b1;
  localparam logic       OWN_IF   = 1'b0;
  localparam logic       OWN_DM   = 1'b1;
  localparam logic [3:0] LAT_C    = 4'(LAT);
  localparam logic [3:0] STARVE_C = 4'(STARVE);

  logic       r_state;
  logic       r_owner;
  logic [3:0] r_cnt;
  logic [3:0] r_starve;
  logic       r_kill;
  logic       r_write;

  logic w_complete;
  logic w_can_issue;
  logic w_if_force;
  logic w_gnt_if;
  logic w_gnt_dm;
  logic w_grant;
  logic w_if_done;
  logic w_dm_done;

  // Grants are gated by reset so every output is quiet while rst_n is low.
  always_comb begin
    w_complete  = (r_state == ST_WAIT) && (r_cnt == 4'd1);
    w_can_issue = rst_n && ((r_state == ST_IDLE) || w_complete);
    w_if_force  = i_if_req && (r_starve == STARVE_C);
    w_gnt_dm    = w_can_issue && i_dm_req && !w_if_force;
    w_gnt_if    = w_can_issue && i_if_req && !w_gnt_dm;
    w_grant     = w_gnt_if || w_gnt_dm;
    w_if_done   = w_complete && (r_owner == OWN_IF);
    w_dm_done   = w_complete && (r_owner == OWN_DM);
  end

  assign o_if_gnt    = w_gnt_if;
  assign o_dm_gnt    = w_gnt_dm;
  assign o_mem_en    = w_grant;
  assign o_mem_we    = w_gnt_dm && i_dm_we;
  assign o_mem_addr  = w_gnt_dm ? i_dm_addr : (w_gnt_if ? i_if_addr : '0);
  assign o_mem_wdata = w_gnt_dm ? i_dm_wdata : '0;
  assign o_mem_size  = w_gnt_dm ? i_dm_size : (w_gnt_if ? 2'b10 : 2'b00);
  assign o_busy      = (r_state == ST_WAIT);

  // A kill arriving in the completion cycle still suppresses that response.
  assign o_if_valid  = w_if_done && !(r_kill || i_if_kill);
  assign o_if_rdata  = w_if_done ? i_mem_rdata : '0;
  assign o_dm_valid  = w_dm_done;
  assign o_dm_rdata  = (w_dm_done && !r_write) ? i_mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_IF;
      r_cnt   <= 4'd0;
      r_kill  <= 1'b0;
      r_write <= 1'b0;
    end else if (w_grant) begin
      r_state <= ST_WAIT;
      r_owner <= w_gnt_dm ? OWN_DM : OWN_IF;
      r_cnt   <= LAT_C;
      r_kill  <= w_gnt_if && i_if_kill;
      r_write <= w_gnt_dm && i_dm_we;
    end else if (r_state == ST_WAIT) begin
      r_cnt <= r_cnt - 4'd1;
      if (w_complete) r_state <= ST_IDLE;
      if ((r_owner == OWN_IF) && i_if_kill) r_kill <= 1'b1;
    end
  end

  // Counts DM wins while a fetch is waiting; saturation hands the next issue slot to IF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= 4'd0;
    end else if (w_gnt_if || !i_if_req) begin
      r_starve <= 4'd0;
    end else if (w_gnt_dm && (r_starve != STARVE_C)) begin
      r_starve <= r_starve + 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then random traffic,
// scored against a cycle-level reference model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int LAT    = 2;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifReq, ifKill, dmReq, dmWe;
  logic [31:0] ifAddr, dmAddr, dmWdata, memRdata;
  logic [1:0]  dmSize;
  logic        o_if_gnt, o_if_valid, o_dm_gnt, o_dm_valid;
  logic        o_mem_en, o_mem_we, o_busy;
  logic [31:0] o_if_rdata, o_dm_rdata, o_mem_addr, o_mem_wdata;
  logic [1:0]  o_mem_size;

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(LAT), .STARVE(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_req(ifReq), .i_if_addr(ifAddr), .i_if_kill(ifKill),
    .o_if_gnt(o_if_gnt), .o_if_valid(o_if_valid), .o_if_rdata(o_if_rdata),
    .i_dm_req(dmReq), .i_dm_we(dmWe), .i_dm_addr(dmAddr), .i_dm_wdata(dmWdata),
    .i_dm_size(dmSize), .o_dm_gnt(o_dm_gnt), .o_dm_valid(o_dm_valid), .o_dm_rdata(o_dm_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_size(o_mem_size), .i_mem_rdata(memRdata),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit ifGntSeen, dmGntSeen;

  typedef struct {
    bit          isIf;
    int          due;
    logic [31:0] data;
    bit          killed;
  } resp_t;

  resp_t pending[$];
  int    starve = 0;
  int    freeAt = 0;
  int    lastGrant = -1000;

  logic [31:0] memArr[logic [31:0]];
  logic [31:0] refMem[logic [31:0]];
  logic [31:0] dueData[int];

  function automatic logic [31:0] initWord(logic [31:0] a);
    if (a == 32'h10) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic logic [31:0] refRead(logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : initWord(a);
  endfunction

  function automatic logic [31:0] memRead(logic [31:0] a);
    return memArr.exists(a) ? memArr[a] : initWord(a);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Memory array with fixed read latency; returns junk whenever no read is due.
  always @(negedge clk) begin
    if (dueData.exists(cyc)) begin
      memRdata = dueData[cyc];
      dueData.delete(cyc);
    end else begin
      memRdata = $urandom;
    end
    #1;
    if (o_mem_en) begin
      if (o_mem_we) memArr[o_mem_addr] = o_mem_wdata;
      else dueData[cyc + LAT] = memRead(o_mem_addr);
    end
  end

  task automatic modelStep();
    int          c;
    bit          expIf, expDm, ifDone, dmDone, ifShow;
    logic [31:0] ifData, dmData;
    resp_t       r;
    c = cyc;
    ifDone = 0; dmDone = 0; ifShow = 0; ifData = '0; dmData = '0;
    if (!rst_n) begin
      checkOutput("rstCtrl", {25'b0, o_if_gnt, o_dm_gnt, o_if_valid, o_dm_valid, o_mem_en, o_mem_we, o_busy}, 32'd0);
      checkOutput("rstData", o_mem_addr | o_mem_wdata | o_if_rdata | o_dm_rdata | {30'b0, o_mem_size}, 32'd0);
      pending.delete();
      starve = 0; freeAt = 0; lastGrant = -1000;
      return;
    end
    if (pending.size() > 0 && pending[0].due == c) begin
      r = pending.pop_front();
      if (r.isIf) begin
        ifDone = 1; ifShow = !(r.killed || ifKill); ifData = r.data;
      end else begin
        dmDone = 1; dmData = r.data;
      end
    end
    checkOutput("ifValid", o_if_valid, ifDone && ifShow);
    checkOutput("dmValid", o_dm_valid, dmDone);
    if (!ifDone) checkOutput("ifRdataIdle", o_if_rdata, 32'd0);
    else if (ifShow) checkOutput("ifRdata", o_if_rdata, ifData);
    checkOutput("dmRdata", o_dm_rdata, dmDone ? dmData : 32'd0);
    checkOutput("busy", o_busy, (c > lastGrant) && (c <= lastGrant + LAT));

    expDm = (c >= freeAt) && dmReq && !(starve == STARVE && ifReq);
    expIf = (c >= freeAt) && ifReq && !expDm;
    checkOutput("ifGnt", o_if_gnt, expIf);
    checkOutput("dmGnt", o_dm_gnt, expDm);
    checkOutput("memEn", o_mem_en, expIf || expDm);
    if (expDm) begin
      checkOutput("memAddrDm", o_mem_addr, dmAddr);
      checkOutput("memWeDm", o_mem_we, dmWe);
      checkOutput("memSizeDm", o_mem_size, dmSize);
      if (dmWe) begin
        checkOutput("memWdata", o_mem_wdata, dmWdata);
        pending.push_back('{isIf: 1'b0, due: c + LAT, data: 32'd0, killed: 1'b0});
        refMem[dmAddr] = dmWdata;
      end else begin
        pending.push_back('{isIf: 1'b0, due: c + LAT, data: refRead(dmAddr), killed: 1'b0});
      end
    end else if (expIf) begin
      checkOutput("memAddrIf", o_mem_addr, ifAddr);
      checkOutput("memWeIf", o_mem_we, 1'b0);
      pending.push_back('{isIf: 1'b1, due: c + LAT, data: refRead(ifAddr), killed: 1'b0});
    end else begin
      checkOutput("memIdle", o_mem_addr | {31'b0, o_mem_we}, 32'd0);
    end
    if (expIf || expDm) begin
      freeAt = c + LAT;
      lastGrant = c;
    end
    // A kill hits any fetch in flight, including one granted this very cycle.
    if (ifKill) foreach (pending[i]) if (pending[i].isIf) pending[i].killed = 1'b1;
    if (expIf || !ifReq) starve = 0;
    else if (expDm && starve < STARVE) starve++;
  endtask

  always @(negedge clk) begin
    #2;
    modelStep();
  end

  task automatic applyStimulus(input bit rstN, input bit ifR, input logic [31:0] ifA, input bit kill,
                               input bit dmR, input bit we, input logic [31:0] dA,
                               input logic [31:0] wd, input logic [1:0] sz);
    @(negedge clk);
    rst_n = rstN; ifReq = ifR; ifAddr = ifA; ifKill = kill;
    dmReq = dmR; dmWe = we; dmAddr = dA; dmWdata = wd; dmSize = sz;
    #3;
    ifGntSeen = o_if_gnt;
    dmGntSeen = o_dm_gnt;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1, 0, 32'd0, 0, 0, 0, 32'd0, 32'd0, 2'd0);
  endtask

  initial begin
    int k, dmCount;
    bit ir, dr, dwe, kill, rstN;
    logic [31:0] ia, da, dwd;
    logic [1:0] dsz;
    rst_n = 0; ifReq = 0; ifKill = 0; dmReq = 0; dmWe = 0;
    ifAddr = '0; dmAddr = '0; dmWdata = '0; dmSize = '0; memRdata = '0;
    repeat (3) @(negedge clk);

    applyStimulus(1, 1, 32'h10, 0, 0, 0, 32'd0, 32'd0, 2'd0);
    checkOutput("fetchFirstGnt", {31'b0, ifGntSeen}, 32'd1);
    idle(4);

    applyStimulus(1, 1, 32'h40, 0, 1, 0, 32'h100, 32'd0, 2'd2);
    checkOutput("simulDmFirst", {30'b0, ifGntSeen, dmGntSeen}, 32'd1);
    k = 0;
    do begin
      applyStimulus(1, 1, 32'h40, 0, 0, 0, 32'd0, 32'd0, 2'd0);
      k++;
    end while (!ifGntSeen && k < 10);
    checkOutput("simulIfWait", k, LAT);
    idle(4);

    for (int rep = 0; rep < 2; rep++) begin
      dmCount = 0; k = 0;
      do begin
        applyStimulus(1, 1, 32'h80 + 32'(rep * 4), 0, 1, 0, 32'h104, 32'd0, 2'd2);
        if (dmGntSeen) dmCount++;
        k++;
      end while (!ifGntSeen && k < 40);
      checkOutput("starveDmGrants", dmCount, STARVE);
    end
    idle(4);

    applyStimulus(1, 0, 32'd0, 0, 1, 1, 32'h200, 32'hDEADBEEF, 2'd2);
    checkOutput("writeGnt", {31'b0, dmGntSeen}, 32'd1);
    idle(3);
    applyStimulus(1, 0, 32'd0, 0, 1, 0, 32'h200, 32'd0, 2'd2);
    idle(4);

    applyStimulus(1, 1, 32'h300, 0, 0, 0, 32'd0, 32'd0, 2'd0);
    applyStimulus(1, 0, 32'd0, 1, 0, 0, 32'd0, 32'd0, 2'd0);
    applyStimulus(1, 1, 32'h304, 0, 0, 0, 32'd0, 32'd0, 2'd0);
    checkOutput("killNextGnt", {31'b0, ifGntSeen}, 32'd1);
    idle(4);

    applyStimulus(1, 1, 32'h400, 0, 0, 0, 32'd0, 32'd0, 2'd0);
    applyStimulus(0, 0, 32'd0, 0, 0, 0, 32'd0, 32'd0, 2'd0);
    applyStimulus(0, 0, 32'd0, 0, 0, 0, 32'd0, 32'd0, 2'd0);
    applyStimulus(1, 1, 32'h404, 0, 0, 0, 32'd0, 32'd0, 2'd0);
    checkOutput("postResetGnt", {31'b0, ifGntSeen}, 32'd1);
    idle(4);

    // Random traffic: requests held until granted, occasional withdrawals, kills and resets.
    ir = 0; dr = 0; ia = '0; da = '0; dwe = 0; dwd = '0; dsz = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!ir) begin
        if ($urandom_range(0, 99) < 50) begin
          ir = 1; ia = 32'($urandom_range(0, 255)) << 2;
        end
      end else if ($urandom_range(0, 99) < 3) ir = 0;
      if (!dr) begin
        if ($urandom_range(0, 99) < 55) begin
          dr = 1; da = 32'($urandom_range(0, 63)) << 2;
          dwe = 1'($urandom_range(0, 1)); dwd = $urandom; dsz = 2'($urandom_range(0, 2));
        end
      end else if ($urandom_range(0, 99) < 3) dr = 0;
      kill = ($urandom_range(0, 99) < 8);
      rstN = !($urandom_range(0, 999) < 5);
      applyStimulus(rstN, ir, ia, kill, dr, dwe, da, dwd, dsz);
      if (ifGntSeen) ir = 0;
      if (dmGntSeen) dr = 0;
    end

    idle(LAT + 3);
    checkOutput("drain", pending.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the pipelined CPU's instruction-fetch stage (IF) and data-memory stage (DM).
- Sits between the pipeline stages and the memory array.
- Serialises accesses, returns read data and write acknowledges to the correct requester, and bounds fetch starvation.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- LAT, 2, memory latency in cycles from mem_en sampled to mem_rdata valid; legal range 1..15.
- STARVE, 4, consecutive DM grants with if_req pending, after which IF gets forced priority; legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  AW  fetch address.
- if_kill  in  1  cancel the outstanding fetch response (branch redirect).
- if_gnt  out  1  fetch accepted this cycle.
- if_valid  out  1  fetch response valid, one-cycle pulse.
- if_rdata  out  DW  fetch data.
- dm_req  in  1  data request; held until dm_gnt.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  write data.
- dm_size  in  2  00 byte, 01 half, 10 word; passed through.
- dm_gnt  out  1  data access accepted this cycle.
- dm_valid  out  1  data response / write ack, one-cycle pulse.
- dm_rdata  out  DW  data read result.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_size  out  2  memory access size.
- mem_rdata  in  DW  memory read data, valid LAT cycles after mem_en.
- busy  out  1  access outstanding.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; owner = IF; latency counter = 0; starve counter = 0.
  - All gnt, valid, mem_en, mem_we and busy outputs are 0; all data and address outputs are 0.
  - A reset asserted mid-access abandons that access: no valid pulse follows reset release.
- FSM has two states, IDLE and WAIT.
- Grant rules:
  - Grants are combinational from the requests and may issue in IDLE, or in WAIT during the cycle the counter expires.
  - Exactly one grant per issue cycle. A requester never sees gnt while another access is outstanding.
- Arbitration priority:
  - DM beats IF, because DM carries the older instruction.
  - Exception: if starve_cnt == STARVE and if_req=1, IF wins.
- Starve counter:
  - Increments, saturating at STARVE, on each dm_gnt while if_req=1.
  - Clears on if_gnt, or in any cycle with if_req=0.
- On a grant in cycle T:
  - mem_en=1 for exactly cycle T.
  - mem_addr, mem_we, mem_wdata and mem_size are muxed from the winner; mem_we=0 for IF.
  - Owner and kill flag are latched, the counter loads LAT, and the FSM goes to WAIT.
  - busy=1 from T+1 until the completion cycle, inclusive.
- Completion:
  - The counter decrements each cycle in WAIT; the completion cycle is the one where the counter equals 1, i.e. T+LAT.
  - In that cycle the owner's valid=1 and the owner's rdata = mem_rdata, combinational pass-through.
  - The non-owner's rdata is held at 0.
  - DM writes still pulse dm_valid; dm_rdata = 0 for writes.
- Back-to-back: a new grant may issue in the completion cycle. Peak rate is one access per LAT cycles; with LAT=1 that is one per cycle.
- if_kill:
  - Sets the kill flag while an IF access is outstanding, including in its grant cycle.
  - At completion, if_valid is suppressed, but timing is unchanged: the port stays busy until T+LAT.
  - Ignored when the owner is DM or the FSM is IDLE.
- Simultaneous if_req and dm_req with no starvation: DM is granted, IF waits.
- If a requester drops req before gnt, the request is withdrawn; no error is raised.
- The mem_* outputs are 0 in any cycle with mem_en=0.

Test Plan:
- Reset, then if_req with if_addr=0x00000010, LAT=2 -> if_gnt and mem_en at cycle 0, mem_addr=0x10; if_valid at cycle 2 with if_rdata = mem_rdata (0x00500093); busy=1 in cycles 1-2.
- Simultaneous if_req and dm_req (read 0x100) -> dm_gnt first, dm_valid at +2; if_gnt in the same cycle as dm_valid; if_valid 2 cycles later.
- dm_req held continuously with if_req held, STARVE=4 -> exactly 4 dm_gnt, then if_gnt on the 5th issue; starve counter returns to 0.
- DM write 0xDEADBEEF to 0x200, dm_size=10 -> mem_we=1, mem_wdata=0xDEADBEEF for one cycle; dm_valid at +LAT with dm_rdata=0.
- Fetch granted, if_kill pulsed one cycle later -> no if_valid; busy still 1 through +LAT; next grant possible at +LAT.
- rst driven low one cycle after a grant -> all outputs 0 immediately; after release, no stale valid; a fresh if_req is granted in its first cycle.
